// File: rtl/counter_rev_pkg.sv
// Shared definitions for the reversible modulo counter: direction encodings
// and the terminal-count predicate used by the RTL and its bench.
package counter_rev_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Terminal count: top of range when counting up, zero when counting down.
  function automatic logic tc_hit(input logic [31:0] cnt,
                                  input logic        dir,
                                  input logic [32:0] modulus);
    logic [32:0] last_v;
    last_v = modulus - 33'd1;
    if (dir == DIR_UP) begin
      return ({1'b0, cnt} == last_v);
    end else begin
      return (cnt == 32'd0);
    end
  endfunction

endpackage

// File: rtl/counter_rev_tc.sv
// Combinational terminal-count detector for counter_rev_mod.
module counter_rev_tc
  import counter_rev_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             dir,
  output logic             tc
);

  assign tc = tc_hit(32'(cnt), dir, 33'(MODULUS));

endmodule

// File: rtl/counter_rev_mod.sv
// Reversible modulo-N counter with synchronous load, enable and ripple carry.
// Build option: define COUNTER_REV_MOD_SAT_EN to saturate instead of wrapping.
module counter_rev_mod
  import counter_rev_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             S,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] cnt,
  output logic             Rc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO_C = '0;

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_rev_mod: WIDTH must be 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("counter_rev_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_nxt_s;
  logic             wrap_r;
  logic             wrap_nxt_s;
  logic             tc_s;

  counter_rev_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .cnt (cnt_r),
    .dir (S),
    .tc  (tc_s)
  );

  // Next-state mux: load beats enable beats hold.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    wrap_nxt_s = 1'b0;
    if (load) begin
      if (64'(d) >= MODULUS) begin
        cnt_nxt_s = MAX_C;
      end else begin
        cnt_nxt_s = d;
      end
    end else if (en) begin
      wrap_nxt_s = tc_s;
      if (tc_s) begin
`ifdef COUNTER_REV_MOD_SAT_EN
        cnt_nxt_s = cnt_r;
`else
        cnt_nxt_s = (S == DIR_UP) ? ZERO_C : MAX_C;
`endif
      end else if (S == DIR_UP) begin
        cnt_nxt_s = cnt_r + ONE_C;
      end else begin
        cnt_nxt_s = cnt_r - ONE_C;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= ZERO_C;
      wrap_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign cnt  = cnt_r;
  assign wrap = wrap_r;
  assign Rc   = en & tc_s;

endmodule
